// File: rtl/lsu_arbiter.sv
// Arbitrates the single LSU port between the core and a debug/loader master,
// with bounded debug wait and burst length. Optional stall statistics via LSU_ARB_STATS_EN.
module lsu_arbiter #(
    parameter int unsigned DBG_BURST_MAX = 8,
    parameter int unsigned DBG_WAIT_MAX  = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_core_req,
    input  logic        i_core_wren,
    input  logic [31:0] i_core_addr,
    input  logic [31:0] i_core_wdata,
    output logic [31:0] o_core_rdata,
    output logic        o_core_stall,
    input  logic        i_dbg_req,
    input  logic        i_dbg_wren,
    input  logic [31:0] i_dbg_addr,
    input  logic [31:0] i_dbg_wdata,
    output logic        o_dbg_gnt,
    output logic        o_dbg_ack,
    output logic [31:0] o_dbg_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata
`ifdef LSU_ARB_STATS_EN
    ,
    output logic [31:0] o_stall_cnt
`endif
);

    localparam int unsigned WW = $clog2(DBG_WAIT_MAX) + 1;
    localparam int unsigned BW = $clog2(DBG_BURST_MAX) + 1;
    localparam logic [WW-1:0] WAIT_LAST  = WW'(DBG_WAIT_MAX - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(DBG_BURST_MAX - 1);

    typedef enum logic [0:0] {StCore, StDbg} state_e;

    state_e          state_q;
    logic [WW-1:0]   wait_cnt_q;
    logic [BW-1:0]   burst_cnt_q;
    logic            dbg_ack_q;
    logic [31:0]     dbg_rdata_q;
    logic            dbg_own;
    logic            dbg_gnt;

    assign dbg_own = (state_q == StDbg);
    assign dbg_gnt = dbg_own & i_dbg_req;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= StCore;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            dbg_ack_q <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_rdata_q <= i_mem_rdata;
                burst_cnt_q <= burst_cnt_q + BW'(1);
            end
            case (state_q)
                StCore: begin
                    if (i_dbg_req) begin
                        // Idle core yields at once; a busy core yields after the wait bound.
                        if (!i_core_req || wait_cnt_q == WAIT_LAST) begin
                            state_q     <= StDbg;
                            wait_cnt_q  <= '0;
                            burst_cnt_q <= '0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WW'(1);
                        end
                    end else begin
                        wait_cnt_q <= '0;
                    end
                end
                StDbg: begin
                    if (!i_dbg_req || (dbg_gnt && burst_cnt_q == BURST_LAST)) begin
                        state_q <= StCore;
                    end
                end
                default: state_q <= StCore;
            endcase
        end
    end

    assign o_core_rdata = i_mem_rdata;
    assign o_core_stall = dbg_own;
    assign o_dbg_gnt    = dbg_gnt;
    assign o_dbg_ack    = dbg_ack_q;
    assign o_dbg_rdata  = dbg_rdata_q;
    assign o_mem_addr   = dbg_own ? i_dbg_addr  : i_core_addr;
    assign o_mem_wdata  = dbg_own ? i_dbg_wdata : i_core_wdata;
    // Writes are suppressed while reset is held so a reset mid-burst cannot leak a store.
    assign o_mem_wren   = i_reset & (dbg_own ? (i_dbg_wren & i_dbg_req)
                                             : (i_core_wren & i_core_req));

`ifdef LSU_ARB_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_cnt_q <= '0;
        end else if (dbg_own && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: directed vector table, burst and reset sequences,
// and random traffic against a cycle-level ownership model.
module tb_lsu_arbiter;

    localparam int unsigned BURST = 8;
    localparam int unsigned WAITM = 4;

    logic        clk;
    logic        rst;
    logic        core_req, core_wren;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        dbg_req, dbg_wren;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_ack;
    logic [31:0] dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wren;
`ifdef LSU_ARB_STATS_EN
    logic [31:0] stall_cnt;
`endif

    logic [31:0] mem [0:16383];
    assign mem_rdata = mem[mem_addr[15:2]];

    lsu_arbiter #(
        .DBG_BURST_MAX(BURST),
        .DBG_WAIT_MAX (WAITM)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_core_req  (core_req),
        .i_core_wren (core_wren),
        .i_core_addr (core_addr),
        .i_core_wdata(core_wdata),
        .o_core_rdata(core_rdata),
        .o_core_stall(core_stall),
        .i_dbg_req   (dbg_req),
        .i_dbg_wren  (dbg_wren),
        .i_dbg_addr  (dbg_addr),
        .i_dbg_wdata (dbg_wdata),
        .o_dbg_gnt   (dbg_gnt),
        .o_dbg_ack   (dbg_ack),
        .o_dbg_rdata (dbg_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wren  (mem_wren),
        .i_mem_rdata (mem_rdata)
`ifdef LSU_ARB_STATS_EN
        ,
        .o_stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port, how long debug has waited, grants this period.
    bit          m_dbg;
    int          m_wait, m_burst, m_stalls;
    bit          m_ack;
    logic [31:0] m_rdata;
    bit          obs_gnt, obs_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dbg = 0; m_wait = 0; m_burst = 0; m_stalls = 0; m_ack = 0; m_rdata = '0;
    endtask

    // One clock cycle: inputs are already driven (at negedge).
    task automatic cycle();
        logic [31:0] e_addr, e_wdata, rd, s_addr, s_wdata;
        logic        e_wren, e_gnt, s_wren;
        #1;
        e_gnt   = m_dbg & dbg_req;
        e_addr  = m_dbg ? dbg_addr : core_addr;
        e_wdata = m_dbg ? dbg_wdata : core_wdata;
        e_wren  = rst & (m_dbg ? (dbg_wren & dbg_req) : (core_wren & core_req));
        rd      = mem[e_addr[15:2]];
        chk("core_stall", {31'd0, core_stall}, {31'd0, m_dbg});
        chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, e_gnt});
        chk("dbg_ack", {31'd0, dbg_ack}, {31'd0, m_ack});
        chk("dbg_rdata", dbg_rdata, m_rdata);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_wren", {31'd0, mem_wren}, {31'd0, e_wren});
        chk("core_rdata", core_rdata, rd);
        obs_gnt = dbg_gnt; obs_stall = core_stall;
        s_wren = mem_wren; s_addr = mem_addr; s_wdata = mem_wdata;
        @(posedge clk);
        #1;
        if (s_wren) mem[s_addr[15:2]] = s_wdata;
        if (rst) begin
            if (!m_dbg) begin
                m_ack = 0;
                if (dbg_req && (!core_req || m_wait == int'(WAITM) - 1)) begin
                    m_dbg = 1; m_wait = 0; m_burst = 0;
                end else if (dbg_req) m_wait++;
                else m_wait = 0;
            end else begin
                m_stalls++;
                m_ack = e_gnt;
                if (e_gnt) m_rdata = rd;
                if (!dbg_req || m_burst == int'(BURST) - 1) m_dbg = 0;
                else m_burst++;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        creq, cwren;
        logic [31:0] caddr, cwdata;
        logic        dreq, dwren;
        logic [31:0] daddr, dwdata;
        logic        e_stall, e_gnt, e_ack, e_wren;
        logic [31:0] e_addr, e_drdata;
    } vec_t;

    vec_t tbl [13];

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
        core_req = cr; core_wren = cw; core_addr = ca; core_wdata = cd;
        dbg_req = dr; dbg_wren = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    initial begin
        int idx, run, nruns, gaps, bad, grants;
        bit waiting;
        int runs [4];

        for (int i = 0; i < 16384; i++) mem[i] = '0;
        mem[32'h2000 >> 2] = 32'hDEAD_BEEF;
        model_reset();

        tbl[0]  = '{1, 1, 32'h7000, 32'h55, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h7000, 32'h0};
        tbl[1]  = '{1, 0, 32'h2000, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h2000, 32'h0};
        tbl[2]  = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h2000, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0};
        tbl[3]  = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h2000, 32'h0, 1, 1, 0, 0, 32'h2000, 32'h0};
        tbl[4]  = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 32'h0, 32'hDEAD_BEEF};
        tbl[5]  = '{1, 1, 32'h7004, 32'h66, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h7004,
                    32'hDEAD_BEEF};
        for (int i = 6; i < 10; i++)
            tbl[i] = '{1, 0, 32'h100, 32'h0, 1, 1, 32'h3000, 32'hA5, 0, 0, 0, 0, 32'h100,
                       32'hDEAD_BEEF};
        tbl[10] = '{1, 0, 32'h100, 32'h0, 1, 1, 32'h3000, 32'hA5, 1, 1, 0, 1, 32'h3000,
                    32'hDEAD_BEEF};
        tbl[11] = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0};
        tbl[12] = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0};

        // Reset with a core store presented: the write must be held off.
        rst = 1'b0;
        drive(1, 1, 32'h7000, 32'h55, 0, 0, 0, 0);
        @(negedge clk);
        cycle();
        chk("reset_wren", {31'd0, mem_wren}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].creq, tbl[i].cwren, tbl[i].caddr, tbl[i].cwdata,
                  tbl[i].dreq, tbl[i].dwren, tbl[i].daddr, tbl[i].dwdata);
            #1;
            chk($sformatf("vec%0d_stall", i), {31'd0, core_stall}, {31'd0, tbl[i].e_stall});
            chk($sformatf("vec%0d_gnt", i), {31'd0, dbg_gnt}, {31'd0, tbl[i].e_gnt});
            chk($sformatf("vec%0d_ack", i), {31'd0, dbg_ack}, {31'd0, tbl[i].e_ack});
            chk($sformatf("vec%0d_wren", i), {31'd0, mem_wren}, {31'd0, tbl[i].e_wren});
            chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_drdata", i), dbg_rdata, tbl[i].e_drdata);
            cycle();
        end
        chk("core_store_landed", mem[32'h7000 >> 2], 32'h55);
        chk("dbg_store_landed", mem[32'h3000 >> 2], 32'hA5);

        // 20-write debug burst with an idle core.
        idx = 0; run = 0; nruns = 0; gaps = 0; waiting = 0;
        for (int i = 0; i < 4; i++) runs[i] = 0;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, 0, idx < 20, 1, 32'h4000 + 32'(idx) * 4, 32'h1000 + 32'(idx));
            cycle();
            if (waiting && !obs_stall) begin gaps++; waiting = 0; end
            if (obs_gnt) begin
                run++; idx++;
            end else if (run > 0) begin
                if (nruns < 4) runs[nruns] = run;
                nruns++; run = 0;
            end
            if (run == int'(BURST)) begin
                if (nruns < 4) runs[nruns] = run;
                nruns++; run = 0;
                if (idx < 20) waiting = 1;
            end
        end
        chk("burst_grants", 32'(idx), 32'd20);
        chk("burst_nruns", 32'(nruns), 32'd3);
        chk("burst_run0", 32'(runs[0]), 32'd8);
        chk("burst_run1", 32'(runs[1]), 32'd8);
        chk("burst_run2", 32'(runs[2]), 32'd4);
        chk("burst_core_gaps", 32'(gaps), 32'd2);
        bad = 0;
        for (int i = 0; i < 20; i++)
            if (mem[(32'h4000 >> 2) + i] !== 32'h1000 + 32'(i)) bad++;
        chk("burst_writes_bad", 32'(bad), 32'd0);
`ifdef LSU_ARB_STATS_EN
        chk("stall_cnt", stall_cnt, 32'(m_stalls));
`endif

        // Reset asserted right after the 3rd grant of a burst.
        grants = 0;
        for (int c = 0; c < 10 && grants < 3; c++) begin
            drive(0, 0, 0, 0, 1, 1, 32'h5000 + 32'(grants) * 4, 32'hBEEF_0000 + 32'(grants));
            cycle();
            if (obs_gnt) grants++;
        end
        chk("rst_pre_grants", 32'(grants), 32'd3);
        dbg_addr = 32'h5000 + 32'(grants) * 4;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        cycle();
        cycle();
        dbg_req = 1'b0;
        rst = 1'b1;
        cycle();
        chk("rst_after_stall", {31'd0, obs_stall}, 32'd0);
        chk("rst_after_rdata", dbg_rdata, 32'd0);
        chk("rst_no_write", mem[(32'h5000 >> 2) + 3], 32'd0);

        // Random traffic; debug master honours hold-until-grant.
        dbg_req = 1'b0;
        for (int c = 0; c < 400; c++) begin
            core_req   = 1'($urandom_range(0, 1));
            core_wren  = 1'($urandom_range(0, 1));
            core_addr  = $urandom & 32'h0000_FFFC;
            core_wdata = $urandom;
            if (!dbg_req || obs_gnt) begin
                dbg_req   = ($urandom_range(0, 2) != 0);
                dbg_wren  = 1'($urandom_range(0, 1));
                dbg_addr  = $urandom & 32'h0000_FFFC;
                dbg_wdata = $urandom;
            end
            obs_gnt = 0;
            cycle();
        end
`ifdef LSU_ARB_STATS_EN
        chk("stall_cnt_rand", stall_cnt, 32'(m_stalls));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
